// File: rtl/phaser_in_tap_ctrl_if.sv
// Command/response handshake between a sequencer (master) and the phaser
// tap controller (slave).
interface phaser_in_tap_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [5:0] cmd_arg;
    logic [1:0] cmd_rank;
    logic       rsp_valid;
    logic [5:0] rsp_data;
    logic       rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, cmd_rank,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, cmd_rank,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/phaser_in_tap_ctrl.sv
// Phaser input tap controller: turns single commands into phaser strobe
// sequences (counter load/read, fine delay steps, ICLKDIV edge advance)
// with settle time between strobes and a one-cycle completion response.
//
// state   | meaning
// IDLE    | ready for a command
// STROBE  | one phaser strobe is high this cycle
// WAIT_RD | waiting for the counter read data to become valid
// SETTLE  | idle cycles after a strobe; fine ops may loop back to STROBE
// DONE    | rsp_valid pulse, back to IDLE next cycle
module phaser_in_tap_ctrl #(
    parameter int SETTLE_CYCLES = 8,
    parameter int READ_LAT      = 2
) (
    input  logic                 SYSCLK,
    input  logic                 DIVIDERST,
    phaser_in_tap_ctrl_if.slave  bus,
    output logic                 counterloaden,
    output logic [5:0]           counterloadval,
    output logic                 counterreaden,
    input  logic [5:0]           counterreadval,
    output logic                 fineenable,
    output logic                 fineinc,
    input  logic                 fineoverflow,
    output logic                 edgeadv,
    output logic [1:0]           ranksel
);

    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_READ  = 3'd1;
    localparam logic [2:0] OP_FINC  = 3'd2;
    localparam logic [2:0] OP_FDEC  = 3'd3;
    localparam logic [2:0] OP_EDGE  = 3'd4;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [2:0] RD_LOAD     = 3'(READ_LAT - 1);

    typedef enum logic [2:0] {IDLE, STROBE, WAIT_RD, SETTLE, DONE} state_t;

    state_t     state;
    logic [2:0] op_q;
    logic [5:0] arg_q;
    logic [5:0] step_cnt;
    logic [7:0] settle_cnt;
    logic [2:0] rd_cnt;
    logic       is_fine;

    assign is_fine = (op_q == OP_FINC) || (op_q == OP_FDEC);

    // Sequencer: state, counters and every output are registered here so the
    // phaser only ever sees glitch-free, single-cycle strobes.
    always_ff @(posedge SYSCLK or negedge DIVIDERST) begin
        if (!DIVIDERST) begin
            state          <= IDLE;
            op_q           <= '0;
            arg_q          <= '0;
            step_cnt       <= '0;
            settle_cnt     <= '0;
            rd_cnt         <= '0;
            bus.cmd_ready  <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_data   <= '0;
            bus.rsp_err    <= 1'b0;
            counterloaden  <= 1'b0;
            counterloadval <= '0;
            counterreaden  <= 1'b0;
            fineenable     <= 1'b0;
            fineinc        <= 1'b0;
            edgeadv        <= 1'b0;
            ranksel        <= '0;
        end else begin
            counterloaden  <= 1'b0;
            counterloadval <= '0;
            counterreaden  <= 1'b0;
            fineenable     <= 1'b0;
            edgeadv        <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        op_q          <= bus.cmd_op;
                        arg_q         <= bus.cmd_arg;
                        ranksel       <= bus.cmd_rank;
                        step_cnt      <= '0;
                        bus.cmd_ready <= 1'b0;
                        fineinc       <= (bus.cmd_op == OP_FINC);
                        case (bus.cmd_op)
                            OP_LOAD: begin
                                state          <= STROBE;
                                counterloaden  <= 1'b1;
                                counterloadval <= bus.cmd_arg;
                            end
                            OP_READ: begin
                                state         <= STROBE;
                                counterreaden <= 1'b1;
                            end
                            OP_FINC, OP_FDEC: begin
                                if (bus.cmd_arg == '0) begin
                                    state         <= DONE;
                                    bus.rsp_valid <= 1'b1;
                                    bus.rsp_data  <= '0;
                                    bus.rsp_err   <= 1'b0;
                                end else begin
                                    state      <= STROBE;
                                    fineenable <= 1'b1;
                                end
                            end
                            OP_EDGE: begin
                                state   <= STROBE;
                                edgeadv <= 1'b1;
                            end
                            default: begin
                                state         <= DONE;
                                bus.rsp_valid <= 1'b1;
                                bus.rsp_data  <= '0;
                                bus.rsp_err   <= 1'b1;
                            end
                        endcase
                    end else begin
                        bus.cmd_ready <= 1'b1;
                    end
                end
                STROBE: begin
                    if (op_q == OP_READ) begin
                        state  <= WAIT_RD;
                        rd_cnt <= RD_LOAD;
                    end else begin
                        state      <= SETTLE;
                        settle_cnt <= SETTLE_LOAD;
                        if (is_fine) step_cnt <= step_cnt + 6'd1;
                    end
                end
                WAIT_RD: begin
                    if (rd_cnt == '0) begin
                        state         <= DONE;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data  <= counterreadval;
                        bus.rsp_err   <= 1'b0;
                    end else begin
                        rd_cnt <= rd_cnt - 3'd1;
                    end
                end
                SETTLE: begin
                    // An overflowing delay line ends the fine op at once;
                    // rsp_data reports how many steps actually landed.
                    if (is_fine && fineoverflow) begin
                        state         <= DONE;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data  <= step_cnt;
                        bus.rsp_err   <= 1'b1;
                        settle_cnt    <= '0;
                    end else if (settle_cnt == '0) begin
                        if (is_fine && (step_cnt != arg_q)) begin
                            state      <= STROBE;
                            fineenable <= 1'b1;
                        end else begin
                            state         <= DONE;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b0;
                            bus.rsp_data  <= is_fine ? step_cnt :
                                             (op_q == OP_LOAD) ? arg_q : 6'd0;
                        end
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    bus.cmd_ready <= 1'b1;
                    fineinc       <= 1'b0;
                    step_cnt      <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_phaser_in_tap_ctrl.sv
// Directed bench for phaser_in_tap_ctrl: a table of commands with
// hand-computed responses, plus a mid-operation reset sequence.
// Cycle numbering: c=0 is the cycle in which the handshake is seen
// (sampled at the falling edge); the DUT accepts on the following rising edge.
module tb_phaser_in_tap_ctrl;

    localparam int SETTLE = 8;
    localparam int RDLAT  = 2;

    logic       SYSCLK = 1'b0;
    logic       DIVIDERST = 1'b0;
    logic       counterloaden, counterreaden, fineenable, fineinc, edgeadv;
    logic [5:0] counterloadval;
    logic [5:0] counterreadval = 6'h00;
    logic       fineoverflow = 1'b0;
    logic [1:0] ranksel;

    phaser_in_tap_ctrl_if bus();

    phaser_in_tap_ctrl #(.SETTLE_CYCLES(SETTLE), .READ_LAT(RDLAT)) dut (
        .SYSCLK         (SYSCLK),
        .DIVIDERST      (DIVIDERST),
        .bus            (bus),
        .counterloaden  (counterloaden),
        .counterloadval (counterloadval),
        .counterreaden  (counterreaden),
        .counterreadval (counterreadval),
        .fineenable     (fineenable),
        .fineinc        (fineinc),
        .fineoverflow   (fineoverflow),
        .edgeadv        (edgeadv),
        .ranksel        (ranksel)
    );

    // 100 MHz system clock
    always #5 SYSCLK = ~SYSCLK;

    typedef struct {
        logic [2:0] op;
        logic [5:0] arg;
        logic [1:0] rank;
        logic [5:0] rdval;
        int         ovf_after;  // raise fineoverflow after this many strobes, 0 = never
        int         kind;       // expected strobe type: 0 none, 1 load, 2 read, 3 fine, 4 edge
        int         n_strobe;
        int         lat;        // cycle index of rsp_valid
        logic [5:0] data;
        logic       err;
        logic       fi;         // expected fineinc from acceptance to DONE
    } vec_t;

    vec_t vecs[11];
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [27:0] all_outs();
        return {bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err,
                counterloaden, counterloadval, counterreaden, fineenable,
                fineinc, edgeadv, ranksel};
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int cnt[5];
        int total, lat, prev, c, wait_cnt;
        int onehot_bad, lval_bad, rank_bad, fi_bad, gap_bad;
        string tag;
        tag = $sformatf("v%0d", idx);
        foreach (cnt[k]) cnt[k] = 0;
        total = 0; lat = -1; prev = -1;
        onehot_bad = 0; lval_bad = 0; rank_bad = 0; fi_bad = 0; gap_bad = 0;
        counterreadval = ~v.rdval;
        fineoverflow   = 1'b0;
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = v.op;
        bus.cmd_arg    = v.arg;
        bus.cmd_rank   = v.rank;
        wait_cnt = 0;
        while (!bus.cmd_ready && wait_cnt < 20) begin
            @(negedge SYSCLK);
            wait_cnt++;
        end
        chk({tag, "_ready_wait"}, int'(bus.cmd_ready), 1);
        for (c = 1; c < 200; c++) begin
            @(negedge SYSCLK);
            if (c == 1) bus.cmd_valid = 1'b0;
            if (int'(counterloaden) + int'(counterreaden) + int'(fineenable) + int'(edgeadv) > 1)
                onehot_bad++;
            if (counterloaden) begin cnt[1]++; total++; if (counterloadval != v.arg) lval_bad++; end
            if (counterreaden) begin cnt[2]++; total++; end
            if (edgeadv)       begin cnt[4]++; total++; end
            if (fineenable) begin
                cnt[3]++; total++;
                if (prev >= 0 && (c - prev) != 1 + SETTLE) gap_bad++;
                prev = c;
            end
            if (ranksel != v.rank) rank_bad++;
            if (fineinc != v.fi) fi_bad++;
            if (v.ovf_after != 0 && cnt[3] == v.ovf_after) fineoverflow = 1'b1;
            counterreadval = (c == 1 + RDLAT) ? v.rdval : ~v.rdval;
            if (bus.rsp_valid) begin
                lat = c;
                break;
            end
        end
        chk({tag, "_latency"}, lat, v.lat);
        chk({tag, "_rsp_data"}, int'(bus.rsp_data), int'(v.data));
        chk({tag, "_rsp_err"}, int'(bus.rsp_err), int'(v.err));
        chk({tag, "_strobes"}, total, v.n_strobe);
        if (v.kind != 0) chk({tag, "_strobe_kind"}, cnt[v.kind], v.n_strobe);
        chk({tag, "_onehot"}, onehot_bad, 0);
        chk({tag, "_loadval"}, lval_bad, 0);
        chk({tag, "_ranksel"}, rank_bad, 0);
        chk({tag, "_fineinc"}, fi_bad, 0);
        chk({tag, "_step_gap"}, gap_bad, 0);
        fineoverflow = 1'b0;
        @(negedge SYSCLK);
        chk({tag, "_valid_1cyc"}, int'(bus.rsp_valid), 0);
        chk({tag, "_ready_after"}, int'(bus.cmd_ready), 1);
        @(negedge SYSCLK);
        chk({tag, "_data_hold"}, int'(bus.rsp_data), int'(v.data));
        chk({tag, "_err_hold"}, int'(bus.rsp_err), int'(v.err));
        chk({tag, "_rank_hold"}, int'(ranksel), int'(v.rank));
    endtask

    initial begin
        int lat_gone, strobes;
        //          op    arg    rk  rdval ovf kind n  lat data   err  fi
        vecs[0]  = '{3'd0, 6'h2A, 2'd2, 6'h00, 0, 1, 1, 10, 6'h2A, 1'b0, 1'b0};
        vecs[1]  = '{3'd1, 6'h00, 2'd1, 6'h15, 0, 2, 1,  4, 6'h15, 1'b0, 1'b0};
        vecs[2]  = '{3'd2, 6'd5,  2'd3, 6'h00, 0, 3, 5, 46, 6'd5,  1'b0, 1'b1};
        vecs[3]  = '{3'd3, 6'd10, 2'd0, 6'h00, 3, 3, 3, 21, 6'd3,  1'b1, 1'b0};
        vecs[4]  = '{3'd2, 6'd0,  2'd1, 6'h00, 0, 0, 0,  1, 6'd0,  1'b0, 1'b1};
        vecs[5]  = '{3'd6, 6'h11, 2'd2, 6'h00, 0, 0, 0,  1, 6'd0,  1'b1, 1'b0};
        vecs[6]  = '{3'd4, 6'h33, 2'd3, 6'h00, 0, 4, 1, 10, 6'd0,  1'b0, 1'b0};
        vecs[7]  = '{3'd7, 6'h3F, 2'd0, 6'h00, 0, 0, 0,  1, 6'd0,  1'b1, 1'b0};
        vecs[8]  = '{3'd1, 6'h00, 2'd2, 6'h2A, 0, 2, 1,  4, 6'h2A, 1'b0, 1'b0};
        vecs[9]  = '{3'd0, 6'h01, 2'd1, 6'h00, 0, 1, 1, 10, 6'h01, 1'b0, 1'b0};
        vecs[10] = '{3'd3, 6'd2,  2'd2, 6'h00, 0, 3, 2, 19, 6'd2,  1'b0, 1'b0};

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_arg   = '0;
        bus.cmd_rank  = '0;

        repeat (3) @(negedge SYSCLK);
        chk("reset_outputs", int'(all_outs()), 0);
        DIVIDERST = 1'b1;
        @(negedge SYSCLK);
        chk("ready_after_reset", int'(bus.cmd_ready), 1);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Reset during SETTLE of a fine op: abort with no response.
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd2;
        bus.cmd_arg   = 6'd4;
        bus.cmd_rank  = 2'd3;
        @(negedge SYSCLK);
        bus.cmd_valid = 1'b0;
        chk("rst_seq_strobe", int'(fineenable), 1);
        repeat (3) @(negedge SYSCLK);
        DIVIDERST = 1'b0;
        #1;
        chk("rst_async_outputs", int'(all_outs()), 0);
        lat_gone = 0; strobes = 0;
        repeat (3) begin
            @(negedge SYSCLK);
            if (bus.rsp_valid) lat_gone++;
            if (fineenable) strobes++;
        end
        chk("rst_no_rsp_valid", lat_gone, 0);
        chk("rst_no_strobe", strobes, 0);
        chk("rst_held_outputs", int'(all_outs()), 0);
        DIVIDERST = 1'b1;
        @(negedge SYSCLK);
        chk("rst_ready_first_edge", int'(bus.cmd_ready), 1);
        run_vec('{3'd4, 6'h00, 2'd1, 6'h00, 0, 4, 1, 10, 6'd0, 1'b0, 1'b0}, 99);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
